// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: access-width codes, FSM states and byte-count helper for mem_ctrl
package mem_ctrl_pkg;
  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  // code 11 is treated as a word access
  function automatic logic [2:0] nbytes(input logic [1:0] w);
    return (w == MemWord || w == 2'b11) ? 3'd4 : (w == MemHalf) ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store requests onto a byte-wide external RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_width,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic                  stallreq_if,
  output logic                  stallreq_mem
);
  state_t      state;
  logic        own_if;
  logic [2:0]  cnt;
  logic [2:0]  n;
  logic [31:0] wdata;
  logic [31:0] acc;
  logic [31:0] asm_w;
  logic [5:0]  sh;
  logic        unused;
  // bytes arrive in address order, so shift each one in from the top
  assign asm_w = {ram_rdata, acc[31:8]};
  assign sh = {3'd4 - n, 3'b000};
  assign stallreq_if = if_req & ~if_done & ~rst;
  assign stallreq_mem = mem_req & ~mem_done & ~rst;
  assign unused = ^{if_addr[31:RAM_ADDR_W], mem_addr[31:RAM_ADDR_W]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      own_if    <= 1'b0;
      cnt       <= '0;
      n         <= '0;
      wdata     <= '0;
      acc       <= '0;
      if_data   <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            own_if    <= 1'b0;
            n         <= nbytes(mem_width);
            ram_addr  <= mem_addr[RAM_ADDR_W-1:0];
            ram_we    <= mem_we;
            ram_wdata <= mem_wdata[7:0];
            wdata     <= {8'd0, mem_wdata[31:8]};
            cnt       <= '0;
            acc       <= '0;
            state     <= mem_we ? WRITE : READ;
          end else if (if_req) begin
            own_if   <= 1'b1;
            n        <= 3'd4;
            ram_addr <= if_addr[RAM_ADDR_W-1:0];
            cnt      <= '0;
            acc      <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (own_if && !if_req) begin
            state <= IDLE;
          end else if (cnt == n) begin
            state <= DONE;
            if (own_if) begin
              if_data <= asm_w >> sh;
              if_done <= 1'b1;
            end else begin
              mem_rdata <= asm_w >> sh;
              mem_done  <= 1'b1;
            end
          end else begin
            if (cnt != 3'd0) acc <= asm_w;
            if (cnt + 3'd1 < n) ram_addr <= ram_addr + RAM_ADDR_W'(1);
            cnt <= cnt + 3'd1;
          end
        end
        WRITE: begin
          if (cnt == n - 3'd1) begin
            state    <= DONE;
            ram_we   <= 1'b0;
            mem_done <= 1'b1;
          end else begin
            cnt       <= cnt + 3'd1;
            ram_addr  <= ram_addr + RAM_ADDR_W'(1);
            ram_wdata <= wdata[7:0];
            wdata     <= wdata >> 8;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
